// File: rtl/arm_bus_pkg.sv
// Shared types and helpers for the ARM data-memory bus bridge.
package arm_bus_pkg;

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} dmem_state_t;

  typedef logic [3:0] strb_t;

  // Read data returned on any faulted access.
  localparam logic [31:0] FAULT_RDATA = 32'h0;

  // One-hot lane enable for a byte access at the given byte offset.
  function automatic strb_t byte_strobe(input logic [1:0] a);
    return strb_t'(4'b0001 << a);
  endfunction

endpackage

// File: rtl/arm_bus_timeout.sv
// Access timeout counter: cleared at the start of an access, counts while
// the access is outstanding, flags the last permitted cycle.
module arm_bus_timeout #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  generate
    if (TIMEOUT_CYCLES == 0) begin : g_off
      assign expired = 1'b0;
    end else begin : g_on
      localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
      localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);
      logic [CW-1:0] cnt;

      // Count outstanding cycles; saturate on the last one.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                     cnt <= '0;
        else if (clear)                 cnt <= '0;
        else if (enable && cnt != LAST) cnt <= cnt + CW'(1);
      end

      // Expires in the TIMEOUT_CYCLES-th busy cycle, so the access has
      // spent exactly TIMEOUT_CYCLES cycles in REQ+RESP when it aborts.
      assign expired = enable && (cnt == LAST);
    end
  endgenerate

endmodule

// File: rtl/arm_dmem_bridge.sv
// Memory-stage access to valid/ready bus bridge with stall, timeout and fault.
module arm_dmem_bridge
  import arm_bus_pkg::*;
#(
  parameter int BusWidth       = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                i_CLK,
  input  logic                i_NRESET,
  input  logic                i_Mem_Read,
  input  logic                i_Mem_Write,
  input  logic                i_Byte,
  input  logic [BusWidth-1:0] i_Addr,
  input  logic [BusWidth-1:0] i_Write_Data,
  output logic [BusWidth-1:0] o_Read_Data,
  output logic                o_Stall,
  output logic                o_Fault,
  output logic                o_Bus_Valid,
  input  logic                i_Bus_Ready,
  output logic                o_Bus_Write,
  output logic [BusWidth-1:0] o_Bus_Addr,
  output logic [BusWidth-1:0] o_Bus_WData,
  output strb_t               o_Bus_Strb,
  input  logic                i_Bus_RValid,
  input  logic [BusWidth-1:0] i_Bus_RData,
  input  logic                i_Bus_Err
);

  dmem_state_t         state, nxt;
  logic                wr_q, byte_q, fault_q;
  logic [BusWidth-1:0] addr_q, wdata_q, rdata_q;

  logic                req, misaligned, latch, tmo_clear, tmo_en, expired;
  logic                upd_fault, fault_d, upd_rdata;
  logic [BusWidth-1:0] rdata_d, rsh, lane_data;

  assign req        = i_Mem_Read | i_Mem_Write;
  assign misaligned = !i_Byte && (i_Addr[1:0] != 2'b00);
  assign tmo_en     = (state == REQ) || (state == RESP);

  // Selected byte lane of the response, zero-extended.
  assign rsh       = i_Bus_RData >> {addr_q[1:0], 3'b000};
  assign lane_data = {{(BusWidth-8){1'b0}}, rsh[7:0]};

  arm_bus_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_tmo (
    .clk     (i_CLK),
    .rst_n   (i_NRESET),
    .clear   (tmo_clear),
    .enable  (tmo_en),
    .expired (expired)
  );

  // State register.
  always_ff @(posedge i_CLK or negedge i_NRESET) begin
    if (!i_NRESET) state <= IDLE;
    else           state <= nxt;
  end

  // Next-state logic and result capture decisions.
  always_comb begin
    nxt       = state;
    latch     = 1'b0;
    tmo_clear = 1'b0;
    upd_fault = 1'b0;
    fault_d   = 1'b0;
    upd_rdata = 1'b0;
    rdata_d   = FAULT_RDATA;
    unique case (state)
      IDLE: if (req) begin
        latch = 1'b1;
        if (misaligned) begin
          nxt       = DONE;
          upd_fault = 1'b1;
          fault_d   = 1'b1;
          upd_rdata = 1'b1;
        end else begin
          nxt       = REQ;
          tmo_clear = 1'b1;
        end
      end
      // A handshake in the expiry cycle still counts as success.
      REQ: if (i_Bus_Ready) begin
        nxt       = wr_q ? DONE : RESP;
        upd_fault = wr_q;
      end else if (expired) begin
        nxt       = DONE;
        upd_fault = 1'b1;
        fault_d   = 1'b1;
        upd_rdata = 1'b1;
      end
      RESP: if (i_Bus_RValid) begin
        nxt       = DONE;
        upd_fault = 1'b1;
        fault_d   = i_Bus_Err;
        upd_rdata = 1'b1;
        if (!i_Bus_Err) rdata_d = byte_q ? lane_data : i_Bus_RData;
      end else if (expired) begin
        nxt       = DONE;
        upd_fault = 1'b1;
        fault_d   = 1'b1;
        upd_rdata = 1'b1;
      end
      DONE: nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Latched request and completion results.
  always_ff @(posedge i_CLK or negedge i_NRESET) begin
    if (!i_NRESET) begin
      wr_q    <= 1'b0;
      byte_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      fault_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      if (latch) begin
        wr_q    <= i_Mem_Write;
        byte_q  <= i_Byte;
        addr_q  <= i_Addr;
        wdata_q <= i_Write_Data;
      end
      if (upd_fault) fault_q <= fault_d;
      if (upd_rdata) rdata_q <= rdata_d;
    end
  end

  // Bus fields are only driven while the request is presented.
  always_comb begin
    o_Bus_Valid = (state == REQ);
    o_Bus_Write = o_Bus_Valid & wr_q;
    o_Bus_Addr  = o_Bus_Valid ? {addr_q[BusWidth-1:2], 2'b00} : '0;
    o_Bus_WData = '0;
    o_Bus_Strb  = '0;
    if (o_Bus_Valid) begin
      o_Bus_WData = byte_q ? {(BusWidth/8){wdata_q[7:0]}} : wdata_q;
      o_Bus_Strb  = byte_q ? byte_strobe(addr_q[1:0]) : 4'b1111;
    end
    o_Stall     = ((state == IDLE) && req) || (state == REQ) || (state == RESP);
    o_Fault     = (state == DONE) && fault_q;
    o_Read_Data = rdata_q;
  end

endmodule
